trisc_fetch_ir: RTL and testbench

- Instruction fetch and instruction-register stage, directly upstream of the TRISC program control unit.
- Holds the program counter and reads instruction words from program memory over a req/ack handshake.
- Latches each instruction word and presents its opcode nibble to the PCU's 4-bit opcode input; the operand field goes to the datapath.
- Fetch and branch requests arrive from the PCU control lines.

---
 rtl/trisc_fetch_ir.sv | 101 ++++++++++
 tb/tb_trisc_fetch_ir.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/trisc_fetch_ir.sv
// Instruction fetch / instruction register for the TRISC core: holds the PC,
// reads program memory over a MemRd/MemAck handshake and latches opcode/operand.
module trisc_fetch_ir #(
    parameter int              IW       = 8,
    parameter int              OPW      = 4,
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              TMO      = 15
) (
    input  logic              SysClock,
    input  logic              SysReset,
    input  logic              FetchReq,
    input  logic              PcLoad,
    input  logic [AW-1:0]     BranchAddr,
    output logic [AW-1:0]     MemAddr,
    output logic              MemRd,
    input  logic              MemAck,
    input  logic [IW-1:0]     MemData,
    output logic [OPW-1:0]    Opcode,
    output logic [IW-OPW-1:0] Operand,
    output logic              IrValid,
    output logic              Busy,
    output logic              Fault,
    output logic [AW-1:0]     PC
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    localparam int             CW       = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0]  TMO_LAST = CW'(TMO - 1);

    logic [0:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_rd;
    logic [IW-1:0] r_ir;
    logic          r_ir_valid;
    logic          r_fault;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge SysClock or posedge SysReset) begin
        if (SysReset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_rd   <= 1'b0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PcLoad) begin
                        r_pc <= BranchAddr;
                    end
                    // A branch in the same cycle as a fetch supplies the fetch address.
                    if (FetchReq) begin
                        r_state    <= S_READ;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= PcLoad ? BranchAddr : r_pc;
                        r_ir_valid <= 1'b0;
                        r_fault    <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                S_READ: begin
                    if (MemAck) begin
                        r_ir       <= MemData;
                        r_ir_valid <= 1'b1;
                        r_mem_rd   <= 1'b0;
                        r_pc       <= r_mem_addr + 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == TMO_LAST) begin
                        // TMO cycles of MemRd without an ack: abandon, PC untouched.
                        r_mem_rd <= 1'b0;
                        r_fault  <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddr = r_mem_addr;
    assign MemRd   = r_mem_rd;
    assign Opcode  = r_ir[IW-1:IW-OPW];
    assign Operand = r_ir[IW-OPW-1:0];
    assign IrValid = r_ir_valid;
    assign Busy    = (r_state == S_READ);
    assign Fault   = r_fault;
    assign PC      = r_pc;

endmodule

// File: tb/tb_trisc_fetch_ir.sv
// Self-checking bench for trisc_fetch_ir: directed scenarios then random
// fetch/branch traffic against a transaction-level model of PC, IR and flags.
module tb_trisc_fetch_ir;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       SysReset;
    logic       FetchReq;
    logic       PcLoad;
    logic [7:0] BranchAddr;
    logic [7:0] MemAddr;
    logic       MemRd;
    logic       MemAck;
    logic [7:0] MemData;
    logic [3:0] Opcode;
    logic [3:0] Operand;
    logic       IrValid;
    logic       Busy;
    logic       Fault;
    logic [7:0] PC;

    int total = 0;
    int bad   = 0;

    // transaction-level model
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    logic       m_irv;
    logic       m_fault;

    always #5 clk = ~clk;

    trisc_fetch_ir #(.IW(8), .OPW(4), .AW(8), .RESET_PC(8'h00), .TMO(TMO)) dut (
        .SysClock(clk), .SysReset(SysReset), .FetchReq(FetchReq), .PcLoad(PcLoad),
        .BranchAddr(BranchAddr), .MemAddr(MemAddr), .MemRd(MemRd), .MemAck(MemAck),
        .MemData(MemData), .Opcode(Opcode), .Operand(Operand), .IrValid(IrValid),
        .Busy(Busy), .Fault(Fault), .PC(PC)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".opcode"},  {28'd0, Opcode},  {28'd0, m_ir[7:4]});
        chk({tag, ".operand"}, {28'd0, Operand}, {28'd0, m_ir[3:0]});
        chk({tag, ".irvalid"}, {31'd0, IrValid}, {31'd0, m_irv});
        chk({tag, ".fault"},   {31'd0, Fault},   {31'd0, m_fault});
        chk({tag, ".pc"},      {24'd0, PC},      {24'd0, m_pc});
        chk({tag, ".busy"},    {31'd0, Busy},    32'd0);
        chk({tag, ".memrd"},   {31'd0, MemRd},   32'd0);
    endtask

    // n = cycles MemRd is high before the ack is sampled; n > TMO means never acked.
    task automatic do_fetch(input string tag, input logic pl, input logic [7:0] ba,
                            input int n, input logic [7:0] data, input logic noise);
        logic [7:0] exp_addr;
        int         limit;
        int         rd;
        exp_addr   = pl ? ba : m_pc;
        if (pl) m_pc = ba;
        FetchReq   = 1'b1;
        PcLoad     = pl;
        BranchAddr = ba;
        tick();
        FetchReq   = 1'b0;
        PcLoad     = 1'b0;
        m_irv      = 1'b0;
        m_fault    = 1'b0;
        chk({tag, ".addr"},     {24'd0, MemAddr}, {24'd0, exp_addr});
        chk({tag, ".busy_rd"},  {30'd0, Busy, MemRd}, 32'd3);
        chk({tag, ".flags_clr"}, {30'd0, IrValid, Fault}, 32'd0);
        limit = (n <= TMO) ? n : TMO;
        rd = 1;
        for (int i = 1; i < limit; i++) begin
            if (noise) begin
                FetchReq   = 1'b1;
                PcLoad     = 1'b1;
                BranchAddr = 8'h77;
            end
            tick();
            FetchReq = 1'b0;
            PcLoad   = 1'b0;
            if (MemRd) rd++;
        end
        if (n <= TMO) begin
            MemAck  = 1'b1;
            MemData = data;
        end
        tick();
        MemAck  = 1'b0;
        MemData = $urandom_range(0, 255);
        chk({tag, ".rd_cycles"}, rd, limit);
        chk({tag, ".addr_hold"}, {24'd0, MemAddr}, {24'd0, exp_addr});
        if (n <= TMO) begin
            m_ir  = data;
            m_irv = 1'b1;
            m_pc  = exp_addr + 8'd1;
        end else begin
            m_fault = 1'b1;
        end
        chk_state(tag);
        $display("fetch %s pl=%0d addr=%02h n=%0d data=%02h -> op=%h opd=%h v=%0d f=%0d pc=%02h",
                 tag, pl, exp_addr, n, data, Opcode, Operand, IrValid, Fault, PC);
    endtask

    task automatic do_load(input string tag, input logic [7:0] ba);
        PcLoad     = 1'b1;
        BranchAddr = ba;
        tick();
        PcLoad     = 1'b0;
        m_pc       = ba;
        chk_state(tag);
        $display("load %s addr=%02h -> pc=%02h", tag, ba, PC);
    endtask

    initial begin
        logic [7:0] d;
        SysReset   = 1'b1;
        FetchReq   = 1'b0;
        PcLoad     = 1'b0;
        BranchAddr = 8'h00;
        MemAck     = 1'b0;
        MemData    = 8'h00;
        m_pc = 8'h00; m_ir = 8'h00; m_irv = 1'b0; m_fault = 1'b0;
        #2;
        chk_state("reset");
        chk("reset.addr", {24'd0, MemAddr}, 32'd0);
        tick();
        tick();
        SysReset = 1'b0;

        do_fetch("first", 1'b0, 8'h00, 1, 8'h8C, 1'b0);
        // IDLE must ignore an ack
        MemAck = 1'b1; MemData = 8'h5A;
        tick();
        MemAck = 1'b0;
        chk_state("idle_ack");
        $display("idle ack ignored -> op=%h opd=%h", Opcode, Operand);

        do_load("to_ff", 8'hFF);
        do_fetch("wrap", 1'b0, 8'h00, 1, 8'h35, 1'b0);
        do_fetch("branch_fetch", 1'b1, 8'h40, 2, 8'hA7, 1'b0);
        do_load("load20", 8'h20);
        do_fetch("timeout", 1'b0, 8'h00, TMO + 1, 8'h00, 1'b0);
        do_fetch("after_to", 1'b0, 8'h00, TMO, 8'h19, 1'b0);
        do_fetch("noise", 1'b0, 8'h00, 6, 8'hE2, 1'b1);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load("rnd_load", 8'($urandom_range(0, 255)));
            end else begin
                d = 8'($urandom_range(0, 255));
                do_fetch("rnd_fetch", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                         $urandom_range(1, TMO + 2), d, 1'($urandom_range(0, 1)));
            end
        end

        // reset in the middle of a read
        do_load("pre_rst", 8'h10);
        FetchReq = 1'b1;
        tick();
        FetchReq = 1'b0;
        tick();
        tick();
        chk("mid.busy", {31'd0, Busy}, 32'd1);
        SysReset = 1'b1;
        #1;
        m_pc = 8'h00; m_ir = 8'h00; m_irv = 1'b0; m_fault = 1'b0;
        chk_state("async_rst");
        chk("async_rst.addr", {24'd0, MemAddr}, 32'd0);
        tick();
        SysReset = 1'b0;
        MemAck   = 1'b1;
        MemData  = 8'hAB;
        tick();
        MemAck = 1'b0;
        chk_state("late_ack");
        $display("reset mid-read -> memrd=%0d pc=%02h op=%h opd=%h", MemRd, PC, Opcode, Operand);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
